sample_mix_scheduler: RTL and testbench



---
 rtl/sample_mix_scheduler.sv | 149 ++++++++++++++
 tb/tb_sample_mix_scheduler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sample_mix_scheduler.sv
// sample_mix_scheduler: shares one sampler code input among NUM_SRC producers.
// At each frame start it polls the enabled sources in order 0..NUM_SRC-1,
// sums the collected codes and updates the held sampler valid/code pair.
// Build option SAMPLE_MIX_AVG_EN: output the average over NUM_SRC slots
// instead of the saturating sum.
module sample_mix_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic                      clr_status,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CODE_W-1:0]         out_code,
  output logic [NUM_SRC-1:0]        underrun,
  output logic                      overrun
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int ACC_W = CODE_W + $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_UPDATE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ready_q, ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CODE_W-1:0]   out_code_q, out_code_d;
  logic [NUM_SRC-1:0]  underrun_q, underrun_d;
  logic                overrun_q, overrun_d;

  logic                frame_start;
  logic                advance;
  logic [NUM_SRC-1:0]  under_set;
  logic [CODE_W-1:0]   cur_code;

`ifdef SAMPLE_MIX_AVG_EN
  // Average over all NUM_SRC slots; the shifted sum always fits CODE_W.
  function automatic logic [CODE_W-1:0] mix_code(input logic [ACC_W-1:0] acc);
    return CODE_W'(acc >> $clog2(NUM_SRC));
  endfunction
`else
  // Saturating sum clamped to the largest code the sampler accepts.
  function automatic logic [CODE_W-1:0] mix_code(input logic [ACC_W-1:0] acc);
    if (acc > ACC_W'({CODE_W{1'b1}})) return {CODE_W{1'b1}};
    else return acc[CODE_W-1:0];
  endfunction
`endif

  assign cur_code    = src_code[int'(idx_q)*CODE_W +: CODE_W];
  assign frame_start = out_ready & ~ready_q;

  // Next-state, polling handshake, mix update and sticky status flags.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ready_d     = out_ready;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    src_ready   = '0;
    under_set   = '0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          acc_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (!src_enable[idx_q]) begin
          advance = 1'b1;
        end else begin
          src_ready[idx_q] = 1'b1;
          if (src_valid[idx_q]) begin
            acc_d   = acc_q + ACC_W'(cur_code);
            advance = 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            under_set[idx_q] = 1'b1;
            advance          = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (advance) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) state_d = S_UPDATE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_UPDATE: begin
        out_valid_d = |src_enable;
        out_code_d  = (|src_enable) ? mix_code(acc_q) : '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flag being set in the same cycle as a clear wins over the clear.
    underrun_d = (clr_status ? '0 : underrun_q) | under_set;
    overrun_d  = (clr_status ? 1'b0 : overrun_q) | (frame_start & (state_q != S_IDLE));
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      underrun_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sample_mix_scheduler.sv
// Self-checking bench for sample_mix_scheduler (NUM_SRC=4, CODE_W=10, TIMEOUT=8).
module tb_sample_mix_scheduler;
  localparam int NS = 4;
  localparam int CW = 10;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     src_valid;
  logic [NS*CW-1:0]  src_code;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     src_enable;
  logic              clr_status;
  logic              out_ready;
  logic              out_valid;
  logic [CW-1:0]     out_code;
  logic [NS-1:0]     underrun;
  logic              overrun;

  sample_mix_scheduler #(.NUM_SRC(NS), .CODE_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_code(src_code),
    .src_ready(src_ready), .src_enable(src_enable), .clr_status(clr_status),
    .out_ready(out_ready), .out_valid(out_valid), .out_code(out_code),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observation of the ready handshake: per-source high-cycle counts,
  // order of assertion, and any cycle with more than one ready high.
  int            rdy_cnt[NS] = '{default: 0};
  int            viol = 0;
  int            ord[$];
  logic [NS-1:0] prev_rdy = '0;
  always @(negedge clk) begin
    if ($countones(src_ready) > 1) viol++;
    for (int i = 0; i < NS; i++) begin
      if (src_ready[i]) rdy_cnt[i]++;
      if (src_ready[i] && !prev_rdy[i]) ord.push_back(i);
    end
    prev_rdy = src_ready;
  end

  // Reference expectations
  int            exp_code  = 0;
  logic          exp_valid = 1'b0;
  logic [NS-1:0] exp_under = '0;
  logic          exp_over  = 1'b0;

  function automatic int model_mix(input int c[NS], input logic [NS-1:0] en, input logic [NS-1:0] vld);
    int sum = 0;
    for (int i = 0; i < NS; i++) if (en[i] && vld[i]) sum += c[i];
    if (en == '0) return 0;
`ifdef SAMPLE_MIX_AVG_EN
    return sum / NS;
`else
    return (sum > 1023) ? 1023 : sum;
`endif
  endfunction

  // Cycles from out_ready rise to the output update.
  function automatic int model_lat(input logic [NS-1:0] en, input logic [NS-1:0] vld);
    int n = 2;
    for (int i = 0; i < NS; i++) n += (en[i] && !vld[i]) ? TO : 1;
    return n;
  endfunction

  task automatic frame(input int c0, input int c1, input int c2, input int c3,
                       input logic [NS-1:0] en, input logic [NS-1:0] vld,
                       input bit toggle, input string tag);
    int c[NS];
    int lat, base_ord, oc, eo;
    int base_cnt[NS];
    c = '{c0, c1, c2, c3};
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      src_code[i*CW +: CW] = CW'(c[i]);
      base_cnt[i] = rdy_cnt[i];
    end
    src_enable = en;
    src_valid  = vld;
    base_ord   = ord.size();
    out_ready  = 1'b1;
    lat = model_lat(en, vld);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (toggle && k == 2) out_ready = 1'b0;
      if (toggle && k == 3) out_ready = 1'b1;
    end
    chk({tag, "_hold_valid"}, out_valid, exp_valid);
    chk({tag, "_hold_code"}, out_code, exp_code);
    @(negedge clk);
    exp_valid = |en;
    exp_code  = model_mix(c, en, vld);
    exp_under = exp_under | (en & ~vld);
    if (toggle) exp_over = 1'b1;
    chk({tag, "_valid"}, out_valid, exp_valid);
    chk({tag, "_code"}, out_code, exp_code);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_underrun"}, underrun, exp_under);
    chk({tag, "_overrun"}, overrun, exp_over);
    for (int i = 0; i < NS; i++)
      chk($sformatf("%s_rdycnt%0d", tag, i), rdy_cnt[i] - base_cnt[i],
          en[i] ? (vld[i] ? 1 : TO) : 0);
    oc = 0;
    for (int j = base_ord; j < ord.size(); j++) oc = oc * 8 + ord[j] + 1;
    eo = 0;
    for (int i = 0; i < NS; i++) if (en[i]) eo = eo * 8 + i + 1;
    chk({tag, "_order"}, oc, eo);
    chk({tag, "_onehot"}, viol, 0);
  endtask

  task automatic pulse_clear(input string tag);
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    exp_under = '0;
    exp_over  = 1'b0;
    chk({tag, "_underrun"}, underrun, exp_under);
    chk({tag, "_overrun"}, overrun, exp_over);
  endtask

  initial begin
    logic [NS-1:0] ren, rvld;
    rst_n = 1'b0; src_valid = '0; src_code = '0; src_enable = '0;
    clr_status = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(100, 200, 300, 50, 4'b1111, 4'b1111, 1'b0, "basic");
    frame(600, 600, 0, 0, 4'b1111, 4'b1111, 1'b0, "sat");
    frame(10, 10, 999, 10, 4'b1111, 4'b1011, 1'b0, "under");
    pulse_clear("under_clr");
    frame(1, 2, 3, 4, 4'b0101, 4'b1111, 1'b0, "mute");
    frame(1, 2, 3, 4, 4'b0000, 4'b1111, 1'b0, "alloff");
    frame(5, 6, 7, 8, 4'b1111, 4'b1110, 1'b1, "overrun");
    pulse_clear("over_clr");

    for (int r = 0; r < 6; r++) begin
      ren  = NS'($urandom);
      rvld = NS'($urandom) | NS'($urandom);
      frame($urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 1023), $urandom_range(0, 1023),
            ren, rvld, 1'b0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of a frame while source 1 is being polled
    frame(1, 2, 3, 4, 4'b1111, 4'b0111, 1'b0, "pre_rst");
    @(negedge clk);
    src_enable = 4'b0010;
    src_valid  = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_poll_ready", src_ready, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_src_ready", src_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_code", out_code, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_overrun", overrun, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TO + 4) @(negedge clk);
    chk("postrst_out_valid", out_valid, 0);
    chk("postrst_out_code", out_code, 0);
    chk("postrst_src_ready", src_ready, 0);
    chk("postrst_underrun", underrun, 0);
    exp_valid = 1'b0; exp_code = 0; exp_under = '0; exp_over = 1'b0;
    frame(100, 200, 300, 50, 4'b1111, 4'b1111, 1'b0, "recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
